// File: rtl/stack_driver_if.sv
// Handshake and buffer-port bundle for stack_driver.
//   slave  : the stack_driver side (consumes in_*, drives out_*, drives buf_* strobes)
//   master : the environment side (upstream source, downstream sink, attached buffer)
// CW is the width of the count field and must match the driver's CW.
interface stack_driver_if #(
    parameter int CW = 4
);
    // Upstream stream
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    // Downstream stream
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    // Attached buffer
    logic          buf_write;
    logic          buf_read;
    logic [7:0]    buf_wdata;
    logic [7:0]    buf_rdata;
    // Status
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          error;

    modport slave (
        input  in_valid, in_data, out_ready, buf_rdata,
        output in_ready, out_valid, out_data,
        output buf_write, buf_read, buf_wdata,
        output count, full, empty, error
    );

    modport master (
        output in_valid, in_data, out_ready, buf_rdata,
        input  in_ready, out_valid, out_data,
        input  buf_write, buf_read, buf_wdata,
        input  count, full, empty, error
    );
endinterface

// File: rtl/stack_driver.sv
// stack_driver: sequences one-cycle write/read strobes to an attached 8-bit
// buffer of DEPTH entries, feeding it from an upstream valid/ready stream and
// draining it into a registered downstream word. Reads take priority whenever
// the output register is empty, so the downstream side is kept fed.
//
// Optional feature: define STACK_DRV_ERR_EN to build the sticky protocol
// checker behind `error`; with it undefined `error` is tied low and no
// detection logic exists.
//
// CW must satisfy 2**(CW-1) == DEPTH so count can hold 0..DEPTH exactly.
module stack_driver #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    stack_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic [7:0]    buf_wdata_q;
    logic          buf_write_q;
    logic          buf_read_q;

    logic          full;
    logic          empty;
    logic          read_pending;
    logic          in_ready;

    // Occupancy flags and the combinational accept condition.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign read_pending = !empty && !out_valid_q;
    assign in_ready     = (state_q == IDLE) && !full && !read_pending;

    // Main sequencer: state, occupancy count, strobes and the output register.
    // NOTE: every register here, including the output data words, is cleared by
    // the asynchronous reset so an aborted operation leaves no stale strobe or
    // data behind; all updates are non-blocking so the whole FSM advances on
    // the same edge from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            buf_wdata_q <= 8'h00;
            buf_write_q <= 1'b0;
            buf_read_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle: they fall unless re-armed below.
            buf_write_q <= 1'b0;
            buf_read_q  <= 1'b0;

            // Downstream handshake; CAPTURE never coincides with a held word.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (read_pending) begin
                        state_q    <= READ;
                        buf_read_q <= 1'b1;
                    end else if (bus.in_valid && in_ready) begin
                        state_q     <= WRITE;
                        buf_write_q <= 1'b1;
                        buf_wdata_q <= bus.in_data;
                    end
                end

                WRITE: begin
                    if (!full) begin
                        count_q <= count_q + ONE_C;
                    end
                    state_q <= IDLE;
                end

                READ: begin
                    if (!empty) begin
                        count_q <= count_q - ONE_C;
                    end
                    state_q <= CAPTURE;
                end

                CAPTURE: begin
                    out_data_q  <= bus.buf_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.buf_write = buf_write_q;
    assign bus.buf_read  = buf_read_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;

`ifdef STACK_DRV_ERR_EN
    // Previous-edge snapshot of the handshake, used to spot illegal changes.
    logic       in_valid_p_q;
    logic       in_ready_p_q;
    logic [7:0] in_data_p_q;
    logic       out_ready_p_q;
    logic       error_q;
    logic       error_d;
    logic       violation;

    // Violation detect: a stalled upstream word must hold, and out_ready must
    // not rise while no word is offered.
    // NOTE: each always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        violation = 1'b0;
        if (in_valid_p_q && !in_ready_p_q &&
            (!bus.in_valid || (bus.in_data != in_data_p_q))) begin
            violation = 1'b1;
        end
        if (bus.out_ready && !out_ready_p_q && !out_valid_q) begin
            violation = 1'b1;
        end
        error_d = error_q | violation;
    end

    // Sticky error flag and handshake snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_valid_p_q  <= 1'b0;
            in_ready_p_q  <= 1'b0;
            in_data_p_q   <= 8'h00;
            out_ready_p_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            in_valid_p_q  <= bus.in_valid;
            in_ready_p_q  <= in_ready;
            in_data_p_q   <= bus.in_data;
            out_ready_p_q <= bus.out_ready;
            error_q       <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_stack_driver.sv
// Directed bench for stack_driver with a counter-addressed (LIFO) buffer model.
// Build with or without STACK_DRV_ERR_EN; the expected error behaviour follows.
`timescale 1ns/1ps
module tb_stack_driver;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    stack_driver_if #(.CW(CW)) bus ();

    stack_driver #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Attached buffer: write at address count, read from address count-1,
    // read data valid the cycle after the read strobe.
    logic [7:0] mem [DEPTH];
    int         writes_n;
    int         reads_n;
    logic       count_over;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            writes_n      <= 0;
            reads_n       <= 0;
            bus.buf_rdata <= 8'h00;
        end else begin
            if (bus.buf_write) begin
                if (int'(bus.count) < DEPTH) mem[int'(bus.count)] <= bus.buf_wdata;
                writes_n <= writes_n + 1;
            end
            if (bus.buf_read) begin
                if (bus.count != '0 && int'(bus.count) <= DEPTH)
                    bus.buf_rdata <= mem[int'(bus.count) - 1];
                reads_n <= reads_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (int'(bus.count) > DEPTH) count_over <= 1'b1;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".count"},     32'(bus.count),     32'd0);
        check({tag, ".full"},      32'(bus.full),      32'd0);
        check({tag, ".empty"},     32'(bus.empty),     32'd1);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".out_data"},  32'(bus.out_data),  32'd0);
        check({tag, ".buf_wdata"}, 32'(bus.buf_wdata), 32'd0);
        check({tag, ".buf_write"}, 32'(bus.buf_write), 32'd0);
        check({tag, ".buf_read"},  32'(bus.buf_read),  32'd0);
        check({tag, ".error"},     32'(bus.error),     32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at a falling edge; checks the offered word and takes it.
    task automatic pop(input logic [7:0] exp);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pop_wait", 32'(n < 20), 32'd1);
        check("pop_data", 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef STACK_DRV_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        count_over    = 1'b0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check_reset("por");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("por_in_ready", 32'(bus.in_ready), 32'd1);

        // Single word through WRITE, READ, CAPTURE
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        check("a5_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("a5_buf_write", 32'(bus.buf_write), 32'd1);
        check("a5_buf_wdata", 32'(bus.buf_wdata), 32'hA5);
        check("a5_in_ready_wr", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("a5_count1", 32'(bus.count), 32'd1);
        check("a5_write_done", 32'(bus.buf_write), 32'd0);
        check("a5_wdata_hold", 32'(bus.buf_wdata), 32'hA5);
        @(negedge clk);
        check("a5_buf_read", 32'(bus.buf_read), 32'd1);
        @(negedge clk);
        check("a5_count0", 32'(bus.count), 32'd0);
        check("a5_read_done", 32'(bus.buf_read), 32'd0);
        @(negedge clk);
        check("a5_out_valid", 32'(bus.out_valid), 32'd1);
        check("a5_out_data", 32'(bus.out_data), 32'hA5);
        check("a5_empty", 32'(bus.empty), 32'd1);

        // Fill the buffer while the output word is held
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        @(negedge clk);
        check("fill_count", 32'(bus.count), 32'(DEPTH));
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_empty", 32'(bus.empty), 32'd0);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_out_hold", 32'(bus.out_data), 32'hA5);
        check("fill_out_valid", 32'(bus.out_valid), 32'd1);

        // Ninth word must not be written; then a stalled-data change
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ninth_no_write", 32'(bus.buf_write), 32'd0);
            check("ninth_count", 32'(bus.count), 32'(DEPTH));
        end
        check("err_before", 32'(bus.error), 32'd0);
        bus.in_data = 8'h22;
        @(negedge clk);
        check("err_set", 32'(bus.error), 32'(exp_err));
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("err_held", 32'(bus.error), 32'(exp_err));

        // Drain: held word first, then buffer order (LIFO)
        pop(8'hA5);
        for (int i = DEPTH; i >= 1; i--) pop(8'(i));
        check("drain_count", 32'(bus.count), 32'd0);
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_full", 32'(bus.full), 32'd0);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        check("drain_no_underflow", 32'(count_over), 32'd0);
        check("err_still_held", 32'(bus.error), 32'(exp_err));

        // Reset in the middle of a read strobe
        push(8'h5A);
        begin
            int n;
            n = 0;
            while (bus.buf_read !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("rst_read_wait", 32'(n < 10), 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge clk);
        #1;
        check("rst_hold_read", 32'(bus.buf_read), 32'd0);
        check("rst_hold_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_read", 32'(bus.buf_read), 32'd0);
            check("rst_no_write", 32'(bus.buf_write), 32'd0);
        end

        // Random traffic: exclusive strobes and count tracking
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_excl", 32'(bus.buf_write & bus.buf_read), 32'd0);
            check("rnd_count", 32'(bus.count), 32'(writes_n - reads_n));
        end
        check("rnd_no_overflow", 32'(count_over), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_driver.md
STACK_DRIVER -- requirements
Module: stack_driver

Interface
REQ-001 DEPTH, 8, number of entries in the attached 8-bit buffer; power of two, 2..128.
REQ-002 CW, 4, width of count output; SHALL satisfy 2**(CW-1) == DEPTH.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word available.
REQ-006 in_data  input  8  upstream word.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_valid  output  1  out_data holds a word for downstream.
REQ-009 out_data  output  8  registered downstream word.
REQ-010 out_ready  input  1  downstream takes out_data this cycle.
REQ-011 buf_write  output  1  one-cycle write strobe to buffer.
REQ-012 buf_read  output  1  one-cycle read strobe to buffer.
REQ-013 buf_wdata  output  8  registered write data to buffer.
REQ-014 buf_rdata  input  8  buffer read data, valid the cycle after buf_read.
REQ-015 count  output  CW  words currently held in buffer, 0..DEPTH.
REQ-016 full  output  1  count == DEPTH.
REQ-017 empty  output  1  count == 0.
REQ-018 error  output  1  sticky protocol-violation flag.

Function
REQ-019 FSM states IDLE, WRITE, READ, CAPTURE; only IDLE may choose a new operation.
REQ-020 in_ready SHALL be combinational: (state==IDLE) && !full && !read_pending, where read_pending = !empty && !out_valid.
REQ-021 IDLE: read_pending -> READ (read priority keeps output fed); else in_valid && in_ready -> WRITE, in_data registered into buf_wdata at that edge.
REQ-022 WRITE: buf_write=1 for exactly one cycle; count +1 at cycle end; next IDLE.
REQ-023 READ: buf_read=1 for exactly one cycle; count -1 at cycle end; next CAPTURE.
REQ-024 CAPTURE: out_data <= buf_rdata, out_valid <= 1; next IDLE.
REQ-025 buf_write and buf_read SHALL never be high in the same cycle; neither SHALL be issued when full/empty forbids it.
REQ-026 out_valid && out_ready at an edge clears out_valid; out_data SHALL remain stable while out_valid && !out_ready.
REQ-027 Word order at out_data is the buffer's order (LIFO for the counter-addressed buffer); the block does not reorder.
REQ-028 Latency: accepted word reaches buffer 2 cycles after acceptance; buffered word reaches out_data 2 cycles after leaving IDLE.
REQ-029 count SHALL never wrap: no increment at DEPTH, no decrement at 0.
REQ-030 buf_wdata holds its value outside WRITE.

Reset
REQ-031 reset_n low: state IDLE, count 0, empty 1, full 0, out_valid 0, out_data 0, buf_wdata 0, buf_write 0, buf_read 0, error 0, asynchronously.
REQ-032 Reset asserted during WRITE/READ/CAPTURE aborts the operation; no strobe occurs after assertion; first operation possible the cycle after deassertion edge.

Configuration
REQ-033 Macro STACK_DRV_ERR_EN defined: error sets and stays set (until reset) when in_valid falls or in_data changes while in_valid && !in_ready, or when out_ready rises without out_valid.
REQ-034 Macro STACK_DRV_ERR_EN undefined: error tied to 0, no detection logic synthesized.

Verification
REQ-035 Reset, in_valid=1 in_data=8'hA5, out_ready=0 -> in_ready=1 cycle 1, buf_write pulse cycle 2 with buf_wdata=A5, then READ/CAPTURE, out_valid=1 out_data=A5, count back to 0.
REQ-036 Hold out_valid=1 with out_ready=0, push 8 words 01..08 -> count=8, full=1, in_ready=0, no ninth buf_write.
REQ-037 From full, pulse out_ready each word -> 8 words delivered in buffer order, empty=1 at end, count never below 0.
REQ-038 Assert reset_n low during a buf_read cycle -> all outputs at reset values immediately, no buf_read afterward.
REQ-039 With STACK_DRV_ERR_EN, change in_data 11->22 while full and in_valid=1 -> error=1 next cycle, held until reset; without macro error stays 0.
REQ-040 Random in_valid/out_ready for 10000 cycles -> buf_write&buf_read never both 1, count = writes - reads at every cycle.
